// File: rtl/fifo_drain_pkg.sv
// Shared definitions for the multi-channel FIFO drain arbiter:
// one-hot FSM state encodings, channel-id width derivation and the
// round-robin search used to pick the next channel to drain.
package fifo_drain_pkg;

  localparam int unsigned MAX_CHAN = 16;

  // One-hot state encodings.
  typedef logic [3:0] state_t;
  localparam state_t ST_INIT  = 4'b0001;
  localparam state_t ST_ARB   = 4'b0010;
  localparam state_t ST_LOAD  = 4'b0100;
  localparam state_t ST_READY = 4'b1000;

  // Result of a round-robin search.
  typedef struct packed {
    logic       found;
    logic [3:0] idx;
  } rr_res_t;

  // Channel-id width: at least one bit even for a single channel.
  function automatic int unsigned chan_w(input int unsigned n);
    if (n <= 1) return 1;
    return unsigned'($clog2(n));
  endfunction

  // First non-empty channel at or after ptr, wrapping modulo n.
  // Entries at index >= n are never examined.
  function automatic rr_res_t rr_search(input logic [MAX_CHAN-1:0] empty,
                                        input logic [3:0]          ptr,
                                        input int unsigned         n);
    rr_res_t     res;
    int unsigned idx;
    res = '0;
    for (int unsigned k = 0; k < MAX_CHAN; k++) begin
      idx = (32'(ptr) + k) % n;
      if (k < n && !res.found && !empty[4'(idx)]) begin
        res.found = 1'b1;
        res.idx   = 4'(idx);
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/fifo_drain_arb_rr_arbiter.sv
// Combinational round-robin pick over N_CHAN FIFO empty flags.
// Ports:
//   i_empty   per-channel empty flag (request = not empty)
//   i_rr_ptr  highest-priority channel for this search
//   o_found   some channel is non-empty
//   o_pick    selected channel (valid when o_found)
module rr_arbiter
  import fifo_drain_pkg::*;
#(
  parameter int unsigned N_CHAN = 4,
  parameter int unsigned CHAN_W = 2
) (
  input  logic [N_CHAN-1:0] i_empty,
  input  logic [CHAN_W-1:0] i_rr_ptr,
  output logic              o_found,
  output logic [CHAN_W-1:0] o_pick
);

  rr_res_t w_res;

  // Zero-padding is harmless: the search never looks past N_CHAN.
  always_comb begin
    w_res   = rr_search(MAX_CHAN'(i_empty), 4'(i_rr_ptr), N_CHAN);
    o_found = w_res.found;
    o_pick  = CHAN_W'(w_res.idx);
  end

endmodule

// File: rtl/fifo_drain_arb.sv
// Drains up to N_CHAN raw-data FIFOs (each with a companion index FIFO)
// with round-robin arbitration and a per-grant burst limit, presenting one
// registered word at a time on a valid/accepted handshake.
// Ports:
//   clk, reset     clock, synchronous active-high reset
//   fifo_empty     per-channel empty flags
//   fifo_data      per-channel read data, valid the cycle after a pop
//   fifo_pop       per-channel pop (Mealy, at most one bit high)
//   index_pop      companion index FIFO pop, mirrors fifo_pop
//   out_data/out_chan/out_last/out_valid  registered word to consumer
//   out_accepted   consumer takes the word when high with out_valid
module fifo_drain_arb
  import fifo_drain_pkg::*;
#(
  parameter  int unsigned N_CHAN    = 4,
  parameter  int unsigned DATA_W    = 32,
  parameter  int unsigned MAX_BURST = 4,
  localparam int unsigned CHAN_W    = chan_w(N_CHAN)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_CHAN-1:0]        fifo_empty,
  input  logic [N_CHAN*DATA_W-1:0] fifo_data,
  output logic [N_CHAN-1:0]        fifo_pop,
  output logic [N_CHAN-1:0]        index_pop,
  output logic [DATA_W-1:0]        out_data,
  output logic [CHAN_W-1:0]        out_chan,
  output logic                     out_last,
  output logic                     out_valid,
  input  logic                     out_accepted
);

  localparam int unsigned BCNT_W = $clog2(MAX_BURST + 1);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [CHAN_W-1:0]   r_grant;
  logic [CHAN_W-1:0]   r_rr_ptr;
  logic [BCNT_W-1:0]   r_burst_cnt;
  logic [DATA_W-1:0]   r_out_data;
  logic [CHAN_W-1:0]   r_out_chan;
  logic                r_out_last;
  logic                r_out_valid;

  logic                w_found;
  logic [CHAN_W-1:0]   w_pick;
  logic                w_start;     // ARB: new grant, first pop
  logic                w_capture;   // LOAD: latch popped word
  logic                w_continue;  // READY: accepted, pop next word of burst
  logic                w_release;   // READY: accepted, grant ends
  logic                w_last;
  logic [DATA_W-1:0]   w_chan_data [N_CHAN];

  // Split the flat data bus into per-channel words.
  for (genvar c = 0; c < N_CHAN; c++) begin : g_data
    assign w_chan_data[c] = fifo_data[c*DATA_W +: DATA_W];
  end

  rr_arbiter #(
    .N_CHAN (N_CHAN),
    .CHAN_W (CHAN_W)
  ) u_rr_arbiter (
    .i_empty  (fifo_empty),
    .i_rr_ptr (r_rr_ptr),
    .o_found  (w_found),
    .o_pick   (w_pick)
  );

  // Burst ends on the limit or when the granted FIFO ran dry after the pop.
  assign w_last = (r_burst_cnt == BCNT_W'(MAX_BURST)) || fifo_empty[r_grant];

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_INIT;
    else       r_state <= w_state_nxt;
  end

  // Next-state and control strobes.
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_capture   = 1'b0;
    w_continue  = 1'b0;
    w_release   = 1'b0;
    case (r_state)
      ST_INIT: w_state_nxt = ST_ARB;
      ST_ARB: begin
        if (w_found) begin
          w_start     = 1'b1;
          w_state_nxt = ST_LOAD;
        end
      end
      ST_LOAD: begin
        w_capture   = 1'b1;
        w_state_nxt = ST_READY;
      end
      ST_READY: begin
        if (out_accepted) begin
          // Re-check empty at accept so a pop never hits an empty FIFO.
          if (!r_out_last && !fifo_empty[r_grant]) begin
            w_continue  = 1'b1;
            w_state_nxt = ST_LOAD;
          end else begin
            w_release   = 1'b1;
            w_state_nxt = ST_ARB;
          end
        end
      end
      default: w_state_nxt = ST_INIT;
    endcase
  end

  // Mealy pops: new grant from the arbiter, or continuation of the burst.
  always_comb begin
    fifo_pop = '0;
    if (w_start)         fifo_pop[w_pick]  = 1'b1;
    else if (w_continue) fifo_pop[r_grant] = 1'b1;
  end

  assign index_pop = fifo_pop;

  // Grant, burst counter, round-robin pointer and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_grant     <= '0;
      r_rr_ptr    <= '0;
      r_burst_cnt <= '0;
      r_out_data  <= '0;
      r_out_chan  <= '0;
      r_out_last  <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      if (w_start) begin
        r_grant     <= w_pick;
        r_burst_cnt <= BCNT_W'(1);
      end
      if (w_continue) r_burst_cnt <= r_burst_cnt + BCNT_W'(1);
      if (w_capture) begin
        r_out_data  <= w_chan_data[r_grant];
        r_out_chan  <= r_grant;
        r_out_last  <= w_last;
        r_out_valid <= 1'b1;
      end
      if (w_continue || w_release) r_out_valid <= 1'b0;
      if (w_release) begin
        r_rr_ptr <= (r_grant == CHAN_W'(N_CHAN - 1)) ? '0 : r_grant + CHAN_W'(1);
      end
    end
  end

  assign out_data  = r_out_data;
  assign out_chan  = r_out_chan;
  assign out_last  = r_out_last;
  assign out_valid = r_out_valid;

endmodule
